lei_cfg_loader: RTL
===================

# lei_cfg_loader

Configuration sequencer for the logic-element interconnect (LEI) switch block. Accepts a stream of 3-bit source-select slots over a valid/ready handshake, assembles them in a shadow register, and commits the full set atomically to the `config_data` array consumed by the LEI. Sits between the bitstream distribution logic and one LEI instance, so the interconnect never sees a partially written configuration.

## Interface
- `LE_INPUTS`, default 4: inputs per logic element; total slots `NSLOT = 4*LE_INPUTS`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `nrst`  in  1  asynchronous active-low reset.
- `en`  in  1  block enable; when low, the FSM, counter and shadow register hold.
- `start`  in  1  single-cycle pulse that begins a load sequence.
- `abort`  in  1  single-cycle pulse that cancels an in-progress load.
- `s_valid`  in  1  slot beat valid.
- `s_data`  in  3  slot value: 0–3 selects source leout0A/0B/1A/1B; 4–7 leaves the input undriven.
- `s_ready`  out  1  slot beat accepted when `s_valid && s_ready`.
- `config_data`  out  3 × [LE_INPUTS-1:0][3:0]  active configuration; element [j][i] is input j of LE i.
- `busy`  out  1  high in LOAD or COMMIT.
- `done`  out  1  one-cycle pulse during COMMIT.
- `rd_idx`  in  $clog2(NSLOT)  readback slot index (only with the macro).
- `rd_data`  out  3  readback value (only with the macro).

## Operation
- States: IDLE, LOAD, COMMIT.
- IDLE: `s_ready` = 0. When `start && en && !abort`, go to LOAD and clear `slot_cnt` to 0.
- LOAD: `s_ready = en`.
  - Each accepted beat writes `shadow[slot_cnt]` and increments `slot_cnt`.
  - Slot k maps to LE `i = k / LE_INPUTS` (0=0A, 1=0B, 2=1A, 3=1B) and input `j = k % LE_INPUTS`.
  - The beat accepted at `slot_cnt == NSLOT-1` moves the FSM to COMMIT. `slot_cnt` does not wrap; it is cleared on entry to LOAD.
- COMMIT: copies the shadow register to `config_data` on the edge ending this cycle, asserts `done`, then returns to IDLE. COMMIT ignores `en`, `abort` and `start`.
- `abort` in LOAD (with `en` high): return to IDLE, discard the shadow, leave `config_data` unchanged. Any beat presented in that cycle is not accepted (`s_ready` is forced to 0).
- `start` in LOAD without `abort`: restart, clearing `slot_cnt` to 0. A beat presented in the same cycle is not accepted.
- `start` and `abort` in the same cycle: `abort` wins.
- `en` low in LOAD: `s_ready` = 0, and the state and counter freeze. Loading resumes where it left off when `en` returns high.
- `config_data` changes only on the COMMIT edge or at reset.

## Timing
- Reset values:
  - `config_data` = all 3'b111 (every input undriven).
  - Shadow register = all 3'b111; `slot_cnt` = 0; state = IDLE.
  - `s_ready`, `busy`, `done`, `rd_data` = 0.
- `start` in cycle 0 puts the FSM in LOAD in cycle 1, with `s_ready` high in cycle 1.
- With back-to-back beats, the last beat is accepted in cycle NSLOT. COMMIT occupies cycle NSLOT+1, with `done` high. The new `config_data` is visible from cycle NSLOT+2, and IDLE is reached in cycle NSLOT+2.
- Minimum start-to-start spacing is NSLOT+2 cycles.
- `s_ready` is combinational from state and `en`. It must not depend on `s_valid`.
- Asserting `nrst` mid-load returns everything to its reset values immediately, including `config_data`.

## Configuration
- `LEI_CFG_READBACK_EN`:
  - Defined: `rd_idx` and `rd_data` exist, and `rd_data` is a registered copy of active `config_data` slot `rd_idx`, with 1-cycle latency.
  - `rd_idx >= NSLOT` returns 3'b111.
  - Not defined: both ports are absent and no readback logic is built.

## Test plan
All scenarios use LE_INPUTS = 4, so NSLOT = 16.
- Reset, then idle for 5 cycles: `config_data` all 3'b111, and `s_ready`, `busy`, `done` stay 0.
- `start`, then 16 back-to-back beats with `s_data = k % 8`: `done` pulses in cycle 17; from cycle 18, `config_data[j][i] = (i*4+j) % 8`.
- Same load with `s_valid` low on every other cycle and `en` low for cycles 5–7: same final `config_data`; no beat accepted while `en` = 0.
- Commit all 3'b000, then `start`, 7 beats of 3'b010, then `abort`: FSM in IDLE the next cycle; `config_data` remains all 3'b000.
- `start` after 10 beats, followed by 16 beats of 3'b001: the first 10 beats are discarded and the final `config_data` is all 3'b001.
- With `LEI_CFG_READBACK_EN`, after the ramp load: `rd_idx` = 6 gives `rd_data` = 3'b110 one cycle later; `rd_idx` = 15 gives 3'b111.

Source files
------------

// File: rtl/lei_cfg_loader.sv
// lei_cfg_loader
//   Configuration sequencer for one LEI switch block. 3-bit source-select
//   slots arrive over a valid/ready handshake, are assembled in a shadow
//   register and committed atomically to config_data, so the interconnect
//   never sees a partially written configuration.
//
//   Slot k is input j = k % LE_INPUTS of LE i = k / LE_INPUTS
//   (LE 0=0A, 1=0B, 2=1A, 3=1B). Slot values 0-3 select a source, 4-7
//   leave the input undriven.
//
//   Optional feature macro: LEI_CFG_READBACK_EN adds rd_idx/rd_data, a
//   registered (1-cycle) readback of the active configuration.
//
// Ports
//   clk         in   clock, rising edge
//   nrst        in   asynchronous active-low reset
//   en          in   block enable; FSM, counter and shadow hold when low
//   start       in   pulse: begin (or restart) a load sequence
//   abort       in   pulse: cancel an in-progress load (wins over start)
//   s_valid     in   slot beat valid
//   s_data      in   slot value [2:0]
//   s_ready     out  slot beat accepted when s_valid && s_ready
//   config_data out  active configuration, [j][i] = input j of LE i
//   busy        out  high in LOAD or COMMIT
//   done        out  one-cycle pulse during COMMIT
//   rd_idx      in   readback slot index (macro only)
//   rd_data     out  readback value (macro only)

module lei_cfg_loader #(
  parameter  int LE_INPUTS = 4,
  localparam int NSLOT     = 4 * LE_INPUTS,
  localparam int IDXW      = $clog2(NSLOT)
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             en,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             s_valid,
  input  logic [2:0]                       s_data,
  output logic                             s_ready,
  output logic [LE_INPUTS-1:0][3:0][2:0]   config_data,
  output logic                             busy,
  output logic                             done
`ifdef LEI_CFG_READBACK_EN
  ,
  input  logic [IDXW-1:0]                  rd_idx,
  output logic [2:0]                       rd_data
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [IDXW-1:0] LAST_SLOT = IDXW'(NSLOT - 1);

  logic [1:0]             state;
  logic [IDXW-1:0]        slot_cnt;
  // Both registers are indexed by slot number k; config_data is a
  // transposed view of active.
  logic [NSLOT-1:0][2:0]  shadow;
  logic [NSLOT-1:0][2:0]  active;

  // A start or abort in LOAD blocks the beat of that same cycle.
  always_comb begin
    s_ready = (state == ST_LOAD) && en && !abort && !start;
    busy    = (state != ST_IDLE);
    done    = (state == ST_COMMIT);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= ST_IDLE;
      slot_cnt <= '0;
      shadow   <= '1;
      active   <= '1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && en && !abort) begin
            state    <= ST_LOAD;
            slot_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (en) begin
            if (abort) begin
              state  <= ST_IDLE;
              shadow <= '1;
            end else if (start) begin
              slot_cnt <= '0;
            end else if (s_valid) begin
              shadow[slot_cnt] <= s_data;
              // Counter parks on the last slot; it is cleared on LOAD entry.
              if (slot_cnt == LAST_SLOT) begin
                state <= ST_COMMIT;
              end else begin
                slot_cnt <= slot_cnt + 1'b1;
              end
            end
          end
        end
        ST_COMMIT: begin
          active <= shadow;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_le
    for (genvar gj = 0; gj < LE_INPUTS; gj++) begin : g_in
      assign config_data[gj][gi] = active[gi*LE_INPUTS + gj];
    end
  end

`ifdef LEI_CFG_READBACK_EN
  localparam logic [IDXW:0] NSLOT_W = (IDXW+1)'(NSLOT);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_data <= '0;
    end else if ({1'b0, rd_idx} < NSLOT_W) begin
      rd_data <= active[rd_idx];
    end else begin
      rd_data <= 3'b111;
    end
  end
`endif

endmodule
